// File: rtl/seq_alu.sv
// Sequential signed ALU: single-cycle arithmetic/logic ops plus a WIDTH-cycle
// shift-add signed multiplier, with a registered result and a one-cycle done pulse.
module seq_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    input  logic [2:0]       opc,
    output logic [WIDTH-1:0] W,
    output logic             zer,
    output logic             neg,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_w;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplr;
    logic             r_neg_p;

    logic [WIDTH:0]   w_add;
    logic [WIDTH+1:0] w_b2a;
    logic [WIDTH+1:0] w_x3;
    logic [WIDTH-1:0] w_alu;
    logic             w_alu_ovf;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [PW-1:0]    w_acc_next;
    logic [PW-1:0]    w_prod;
    logic             w_prod_ovf;
    logic             w_accept;

    assign w_accept = (r_state == S_IDLE) && start;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start && (opc == 3'b111)) w_state_next = S_MUL;
            S_MUL:  if (r_cnt == CW'(1)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Wide intermediate results so overflow can be judged on the exact value
    assign w_add = {A[WIDTH-1], A} + {B[WIDTH-1], B} + (WIDTH + 1)'(C);
    assign w_b2a = {{2{B[WIDTH-1]}}, B} + {A[WIDTH-1], A, 1'b0};
    assign w_x3  = {{2{B[WIDTH-1]}}, B} + {B[WIDTH-1], B, 1'b0};

    // Single-cycle operation result and overflow
    always_comb begin
        w_alu     = '0;
        w_alu_ovf = 1'b0;
        case (opc)
            3'b000: begin
                w_alu     = w_add[WIDTH-1:0];
                w_alu_ovf = w_add[WIDTH] ^ w_add[WIDTH-1];
            end
            3'b001: begin
                w_alu     = w_b2a[WIDTH-1:0];
                w_alu_ovf = ~((w_b2a[WIDTH+1] == w_b2a[WIDTH]) &&
                              (w_b2a[WIDTH] == w_b2a[WIDTH-1]));
            end
            3'b010: begin
                w_alu     = B + WIDTH'(1);
                w_alu_ovf = (B == {1'b0, {(WIDTH-1){1'b1}}});
            end
            // Upper WIDTH bits of the sign-extended 3*B implement the floor shift
            3'b011: w_alu = WIDTH'(w_x3 >> 2);
            3'b100: w_alu = A & B;
            3'b101: w_alu = A | B;
            3'b110: w_alu = ~B;
            default: begin
                w_alu     = '0;
                w_alu_ovf = 1'b0;
            end
        endcase
    end

    assign w_abs_a    = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
    assign w_abs_b    = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
    assign w_acc_next = r_acc + (r_mplr[0] ? r_mcand : '0);
    assign w_prod     = r_neg_p ? (~w_acc_next + PW'(1)) : w_acc_next;
    assign w_prod_ovf = ~((&w_prod[PW-1:WIDTH-1]) | ~(|w_prod[PW-1:WIDTH-1]));

    // Datapath, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_w     <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_neg_p <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    if (opc == 3'b111) begin
                        r_cnt   <= CW'(WIDTH);
                        r_busy  <= 1'b1;
                        r_acc   <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, w_abs_a};
                        r_mplr  <= w_abs_b;
                        r_neg_p <= A[WIDTH-1] ^ B[WIDTH-1];
                    end else begin
                        r_w    <= w_alu;
                        r_ovf  <= w_alu_ovf;
                        r_done <= 1'b1;
                    end
                end
            end else begin
                r_cnt   <= r_cnt - CW'(1);
                r_acc   <= w_acc_next;
                r_mcand <= {r_mcand[PW-2:0], 1'b0};
                r_mplr  <= {1'b0, r_mplr[WIDTH-1:1]};
                if (r_cnt == CW'(1)) begin
                    r_w    <= w_prod[WIDTH-1:0];
                    r_ovf  <= w_prod_ovf;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign W    = r_w;
    assign zer  = (r_w == '0);
    assign neg  = r_w[WIDTH-1];
    assign ovf  = r_ovf;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=16.
module tb_seq_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        C;
    logic [2:0]  opc;
    logic [15:0] W;
    logic        zer;
    logic        neg;
    logic        ovf;
    logic        busy;
    logic        done;

    int n_total;
    int n_bad;

    seq_alu #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .C    (C),
        .opc  (opc),
        .W    (W),
        .zer  (zer),
        .neg  (neg),
        .ovf  (ovf),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one single-cycle op and leave the bench one cycle after the accept edge
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic c);
        opc = op; A = a; B = b; C = c; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_total++; if (W !== 16'h0000) begin n_bad++; $display("FAIL reset_W got=%h exp=0000", W); end
        n_total++; if (zer !== 1'b1) begin n_bad++; $display("FAIL reset_zer got=%b exp=1", zer); end
        n_total++; if (neg !== 1'b0) begin n_bad++; $display("FAIL reset_neg got=%b exp=0", neg); end
        n_total++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_total++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_add();
        issue(3'b000, 16'h7FFF, 16'h0000, 1'b1);
        n_total++; if (W !== 16'h8000) begin n_bad++; $display("FAIL add_max_W got=%h exp=8000", W); end
        n_total++; if (neg !== 1'b1) begin n_bad++; $display("FAIL add_max_neg got=%b exp=1", neg); end
        n_total++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL add_max_ovf got=%b exp=1", ovf); end
        n_total++; if (done !== 1'b1) begin n_bad++; $display("FAIL add_max_done got=%b exp=1", done); end
        step();
        n_total++; if (done !== 1'b0) begin n_bad++; $display("FAIL add_done_single got=%b exp=0", done); end
        n_total++; if (W !== 16'h8000) begin n_bad++; $display("FAIL add_hold_W got=%h exp=8000", W); end
        issue(3'b000, 16'h0005, 16'hFFFD, 1'b0);
        n_total++; if (W !== 16'h0002) begin n_bad++; $display("FAIL add_mixed_W got=%h exp=0002", W); end
        n_total++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL add_mixed_ovf got=%b exp=0", ovf); end
        issue(3'b000, 16'h8000, 16'hFFFF, 1'b0);
        n_total++; if (W !== 16'h7FFF) begin n_bad++; $display("FAIL add_negov_W got=%h exp=7fff", W); end
        n_total++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL add_negov_ovf got=%b exp=1", ovf); end
        step();
    endtask

    task automatic test_b2a();
        issue(3'b001, 16'h3000, 16'h1000, 1'b0);
        n_total++; if (W !== 16'h7000) begin n_bad++; $display("FAIL b2a_W got=%h exp=7000", W); end
        n_total++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL b2a_ovf got=%b exp=0", ovf); end
        issue(3'b001, 16'h4000, 16'h0000, 1'b0);
        n_total++; if (W !== 16'h8000) begin n_bad++; $display("FAIL b2a_big_W got=%h exp=8000", W); end
        n_total++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL b2a_big_ovf got=%b exp=1", ovf); end
        step();
    endtask

    task automatic test_inc_scale();
        issue(3'b010, 16'h0000, 16'h7FFF, 1'b0);
        n_total++; if (W !== 16'h8000) begin n_bad++; $display("FAIL inc_max_W got=%h exp=8000", W); end
        n_total++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL inc_max_ovf got=%b exp=1", ovf); end
        issue(3'b010, 16'h0000, 16'hFFFF, 1'b0);
        n_total++; if (zer !== 1'b1) begin n_bad++; $display("FAIL inc_m1_zer got=%b exp=1 W=%h", zer, W); end
        n_total++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL inc_m1_ovf got=%b exp=0", ovf); end
        issue(3'b011, 16'h0000, 16'hFFFB, 1'b0);
        n_total++; if (W !== 16'hFFFC) begin n_bad++; $display("FAIL scale_m5_W got=%h exp=fffc", W); end
        n_total++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL scale_m5_ovf got=%b exp=0", ovf); end
        issue(3'b011, 16'h0000, 16'd100, 1'b0);
        n_total++; if (W !== 16'd75) begin n_bad++; $display("FAIL scale_100_W got=%h exp=004b", W); end
        n_total++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL scale_100_ovf got=%b exp=0", ovf); end
        step();
    endtask

    task automatic test_logic();
        issue(3'b100, 16'hF0F0, 16'h3C3C, 1'b0);
        n_total++; if (W !== 16'h3030) begin n_bad++; $display("FAIL and_W got=%h exp=3030", W); end
        issue(3'b101, 16'hF0F0, 16'h3C3C, 1'b0);
        n_total++; if (W !== 16'hFCFC) begin n_bad++; $display("FAIL or_W got=%h exp=fcfc", W); end
        issue(3'b110, 16'hF0F0, 16'h3C3C, 1'b0);
        n_total++; if (W !== 16'hC3C3) begin n_bad++; $display("FAIL not_W got=%h exp=c3c3", W); end
        n_total++; if (done !== 1'b1) begin n_bad++; $display("FAIL not_done got=%b exp=1", done); end
        step();
    endtask

    // Multiply with start pulses and operand changes while busy
    task automatic test_mul_busy();
        int lat;
        int busy_cnt;
        issue(3'b111, 16'hFFFD, 16'h0007, 1'b0);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (lat == 3 || lat == 7) begin
                start = 1'b1; opc = 3'b000; A = 16'd100; B = 16'd100;
            end else begin
                start = 1'b0;
            end
            step();
            lat++;
        end
        start = 1'b0;
        n_total++; if (lat !== 16) begin n_bad++; $display("FAIL mul_latency got=%0d exp=16", lat); end
        n_total++; if (busy_cnt !== 16) begin n_bad++; $display("FAIL mul_busy_cycles got=%0d exp=16", busy_cnt); end
        n_total++; if (W !== 16'hFFEB) begin n_bad++; $display("FAIL mul_m3x7_W got=%h exp=ffeb", W); end
        n_total++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL mul_m3x7_ovf got=%b exp=0", ovf); end
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mul_busy_end got=%b exp=0", busy); end
        step();
        n_total++; if (done !== 1'b0) begin n_bad++; $display("FAIL mul_done_single got=%b exp=0", done); end
        n_total++; if (W !== 16'hFFEB) begin n_bad++; $display("FAIL mul_hold_W got=%h exp=ffeb", W); end
    endtask

    task automatic test_mul_values();
        int lat;
        issue(3'b111, 16'd300, 16'd300, 1'b0);
        lat = 0;
        while (!done && lat < 40) begin step(); lat++; end
        n_total++; if (W !== 16'h5F90) begin n_bad++; $display("FAIL mul_300sq_W got=%h exp=5f90", W); end
        n_total++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL mul_300sq_ovf got=%b exp=1", ovf); end
        step();
        issue(3'b111, 16'hFF80, 16'h0100, 1'b0);
        lat = 0;
        while (!done && lat < 40) begin step(); lat++; end
        n_total++; if (W !== 16'h8000) begin n_bad++; $display("FAIL mul_minfit_W got=%h exp=8000", W); end
        n_total++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL mul_minfit_ovf got=%b exp=0", ovf); end
        step();
    endtask

    task automatic test_reset_mid_mul();
        int done_cnt;
        issue(3'b111, 16'd9, 16'd9, 1'b0);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        #1;
        n_total++; if (W !== 16'h0000) begin n_bad++; $display("FAIL rstmid_W got=%h exp=0000", W); end
        n_total++; if (zer !== 1'b1) begin n_bad++; $display("FAIL rstmid_zer got=%b exp=1", zer); end
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        step();
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) done_cnt++;
        end
        n_total++; if (done_cnt !== 0) begin n_bad++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt); end
        issue(3'b010, 16'h0000, 16'h0000, 1'b0);
        n_total++; if (W !== 16'h0001 || done !== 1'b1) begin n_bad++; $display("FAIL rstmid_restart got W=%h done=%b exp W=0001 done=1", W, done); end
        step();
    endtask

    task automatic test_back_to_back();
        opc = 3'b010; A = 16'h0000; C = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            B = 16'(i);
            step();
            n_total++; if (W !== 16'(i + 1)) begin n_bad++; $display("FAIL b2b_W%0d got=%h exp=%h", i, W, 16'(i + 1)); end
            n_total++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done%0d got=%b exp=1", i, done); end
        end
        start = 1'b0;
        step();
        n_total++; if (done !== 1'b0 || W !== 16'h0003) begin n_bad++; $display("FAIL b2b_end got done=%b W=%h exp done=0 W=0003", done, W); end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        C     = 1'b0;
        opc   = 3'b000;
        test_reset();
        test_add();
        test_b2a();
        test_inc_scale();
        test_logic();
        test_mul_busy();
        test_mul_values();
        test_reset_mid_mul();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width, signed two's complement, WIDTH >= 4.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port A  input  WIDTH  signed operand A.
REQ-006 SHALL have port B  input  WIDTH  signed operand B.
REQ-007 SHALL have port C  input  1  carry-in for opc 000.
REQ-008 SHALL have port opc  input  3  operation select.
REQ-009 SHALL have port W  output  WIDTH  registered signed result.
REQ-010 SHALL have port zer  output  1  high when W == 0, derived combinationally from W.
REQ-011 SHALL have port neg  output  1  W[WIDTH-1], derived combinationally from W.
REQ-012 SHALL have port ovf  output  1  registered signed-overflow flag of the last result.
REQ-013 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse marking new W/ovf.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and MUL.
REQ-016 In IDLE with start=1, SHALL latch A, B, C and opc at that clock edge (the accept edge).
REQ-017 For single-cycle ops (opc 000-110), SHALL update W/ovf at the accept edge, pulse done for the following cycle, and remain in IDLE.
REQ-018 opc 000: W = A+B+C; ovf = signed overflow of the WIDTH-bit sum, carry-in included.
REQ-019 opc 001: W = B+2A, computed at WIDTH+2 bits; ovf=1 if the exact result does not fit WIDTH signed; W = low WIDTH bits.
REQ-020 opc 010: W = B+1; ovf=1 only when B is the maximum positive value.
REQ-021 opc 011: W = (3*B) >>> 2, computed at WIDTH+2 bits with arithmetic shift (floor); ovf=0.
REQ-022 opc 100/101/110: W = A&B, A|B and ~B respectively; ovf=0.
REQ-023 opc 111: SHALL perform signed multiply A*B over exactly WIDTH cycles.
REQ-024 Multiply algorithm: shift-add of |A| and |B| into a 2*WIDTH accumulator, one multiplier bit per cycle; at the end, negate if the signs differ.
REQ-025 On accepting opc 111, SHALL enter MUL with counter = WIDTH and busy=1 from the next cycle.
REQ-026 In MUL, SHALL decrement the counter every cycle.
REQ-027 When the counter reaches 1, SHALL at that edge write W = low WIDTH bits of the product, ovf=1 if the product does not fit WIDTH signed, pulse done, and return to IDLE.
REQ-028 Multiply latency SHALL be WIDTH cycles from the accept edge to the edge that asserts done; busy SHALL be high for exactly WIDTH cycles.
REQ-029 start while in MUL SHALL be ignored; latched operands SHALL be unaffected by input changes after the accept edge.
REQ-030 start in the cycle where done=1 (FSM in IDLE) SHALL be accepted, allowing back-to-back operation.
REQ-031 W and ovf SHALL hold their values between done pulses.
REQ-032 done SHALL never be high for two consecutive cycles from the same operation.

Reset
REQ-033 rst=1 SHALL immediately force W=0, ovf=0, done=0, busy=0, FSM to IDLE and counter to 0; zer therefore reads 1 and neg reads 0.
REQ-034 rst asserted mid-multiply SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.

Verification (WIDTH=16)
REQ-035 Scenario: opc 000, A=0x7FFF, B=0, C=1 -> next cycle W=0x8000, neg=1, ovf=1, done=1 for one cycle.
REQ-036 Scenario: opc 011, B=-5 -> W=-4; then B=100 -> W=75; ovf=0 in both cases.
REQ-037 Scenario: opc 111, A=-3, B=7 -> busy high 16 cycles, then W=-21, ovf=0, single done pulse; start pulses during busy have no effect.
REQ-038 Scenario: opc 111, A=300, B=300 -> W=24464 (90000 mod 65536), ovf=1.
REQ-039 Scenario: rst pulsed 5 cycles into a multiply -> W=0, zer=1, busy=0; no done follows.
REQ-040 Scenario: start held high with opc 010, B=0,1,2 on successive cycles -> done high every cycle, W=1,2,3 in order.
